// File: rtl/exec_csr_unit_pkg.sv
// Shared constants for the execute datapath and machine-mode CSR file.
// The optional 64-bit cycle counter is enabled with CSR_COUNTERS_EN.
package exec_csr_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    // ALU operation encoding
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    // Instruction class from the control unit
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_OTHER  = 2'b11;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_AW-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_AW-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_AW-1:0] CSR_MVENDORID = 12'hF11;
    localparam logic [CSR_AW-1:0] CSR_MARCHID   = 12'hF12;
    localparam logic [CSR_AW-1:0] CSR_MIMPID    = 12'hF13;
    localparam logic [CSR_AW-1:0] CSR_MHARTID   = 12'hF14;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_AW-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [CSR_AW-1:0] CSR_CYCLEH    = 12'hC80;

    localparam int unsigned MIP_MSIP    = 3;
    localparam int unsigned MIP_MTIP    = 7;
    localparam int unsigned MIP_MEIP    = 11;
    localparam int unsigned MIP_FAST_LO = 16;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    // Later assignments win: fast 31..16 beat external, then software, then timer
    function automatic logic [4:0] irq_code(input logic [XLEN-1:0] active);
        logic [4:0] code;
        code = 5'(MIP_MTIP);
        if (active[MIP_MTIP]) code = 5'(MIP_MTIP);
        if (active[MIP_MSIP]) code = 5'(MIP_MSIP);
        if (active[MIP_MEIP]) code = 5'(MIP_MEIP);
        for (int i = MIP_FAST_LO; i < XLEN; i++) begin
            if (active[i]) code = 5'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/exec_csr_unit_if.sv
// CSR access bus between the core control unit and the CSR file.
interface exec_csr_unit_if;
    logic        csr_write_enable;
    logic [11:0] csr_address;
    logic [4:0]  csr_immediate;
    logic [31:0] csr_data_in;
    logic [31:0] csr_data_out;

    modport master (
        output csr_write_enable, csr_address, csr_immediate, csr_data_in,
        input  csr_data_out
    );

    modport slave (
        input  csr_write_enable, csr_address, csr_immediate, csr_data_in,
        output csr_data_out
    );
endinterface

// File: rtl/exec_csr_regfile.sv
// Machine-mode CSR storage, Zicsr read/modify/write and interrupt entry.
// Optional mcycle/cycle counter under CSR_COUNTERS_EN.
module exec_csr_regfile
    import exec_csr_unit_pkg::*;
#(
    parameter logic [31:0] MHARTID  = 32'h0,
    parameter logic [31:0] MISA_VAL = 32'h40000100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           func3,
    exec_csr_unit_if.slave       csr,
    input  logic                 irq_external,
    input  logic                 irq_timer,
    input  logic                 irq_software,
    input  logic [15:0]          irq_fast,
    input  logic [XLEN-1:0]      pc_value,
    output logic                 interrupt_taken,
    output logic [XLEN-1:0]      mtvec_out
);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mtval_r;
`ifdef CSR_COUNTERS_EN
    logic [63:0]     mcycle_r;
`endif

    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] wdata;
    logic            do_write;
    logic            pending;
    logic            take_irq;

    assign mip = {irq_fast, 4'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};

    // Read mux; during a write cycle this still shows the pre-write value
    always_comb begin
        rdata = '0;
        case (csr.csr_address)
            CSR_MSTATUS:  rdata = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            CSR_MISA:     rdata = MISA_VAL;
            CSR_MIE:      rdata = mie_r;
            CSR_MTVEC:    rdata = mtvec_r;
            CSR_MSCRATCH: rdata = mscratch_r;
            CSR_MEPC:     rdata = mepc_r;
            CSR_MCAUSE:   rdata = mcause_r;
            CSR_MTVAL:    rdata = mtval_r;
            CSR_MIP:      rdata = mip;
            CSR_MHARTID:  rdata = MHARTID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_CYCLE:   rdata = mcycle_r[31:0];
            CSR_MCYCLEH, CSR_CYCLEH: rdata = mcycle_r[63:32];
`endif
            default:      rdata = '0;
        endcase
    end

    assign csr.csr_data_out = rdata;

    assign src = func3[2] ? XLEN'(csr.csr_immediate) : csr.csr_data_in;

    always_comb begin
        wdata = rdata;
        case (func3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = rdata | src;
            2'b11:   wdata = rdata & ~src;
            default: wdata = rdata;
        endcase
    end

    assign do_write = csr.csr_write_enable && (func3[1:0] != 2'b00);
    assign pending  = mstatus_mie && |(mie_r & mip);
    assign take_irq = pending && !csr.csr_write_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie     <= 1'b0;
            mstatus_mpie    <= 1'b0;
            mie_r           <= '0;
            mtvec_r         <= '0;
            mscratch_r      <= '0;
            mepc_r          <= '0;
            mcause_r        <= '0;
            mtval_r         <= '0;
            interrupt_taken <= 1'b0;
        end else begin
            interrupt_taken <= 1'b0;
            if (do_write) begin
                case (csr.csr_address)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wdata[MSTATUS_MIE];
                        mstatus_mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_r      <= wdata;
                    CSR_MTVEC:    mtvec_r    <= wdata;
                    CSR_MSCRATCH: mscratch_r <= wdata;
                    CSR_MEPC:     mepc_r     <= {wdata[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_r   <= wdata;
                    CSR_MTVAL:    mtval_r    <= wdata;
                    default: ;
                endcase
            end else if (take_irq) begin
                mepc_r          <= {pc_value[31:2], 2'b00};
                mcause_r        <= {1'b1, 26'b0, irq_code(mie_r & mip)};
                mstatus_mpie    <= mstatus_mie;
                mstatus_mie     <= 1'b0;
                interrupt_taken <= 1'b1;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running cycle count; an explicit write replaces that cycle's increment
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_r <= '0;
        end else if (do_write && csr.csr_address == CSR_MCYCLE) begin
            mcycle_r <= {mcycle_r[63:32], wdata};
        end else if (do_write && csr.csr_address == CSR_MCYCLEH) begin
            mcycle_r <= {wdata, mcycle_r[31:0]};
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end
`endif

    assign mtvec_out = mtvec_r;

endmodule

// File: rtl/exec_csr_unit.sv
// Execute datapath (ALU-control decoder + 32-bit ALU) and machine-mode CSR file.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/cycle counter.
module exec_csr_unit
    import exec_csr_unit_pkg::*;
#(
    parameter logic [31:0] MHARTID  = 32'h0,
    parameter logic [31:0] MISA_VAL = 32'h40000100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            is_immediate,
    input  logic [1:0]      aluop_in,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic            op_override_en,
    input  logic [3:0]      op_override,
    output logic [3:0]      aluop_out,
    input  logic [XLEN-1:0] alu_in_x,
    input  logic [XLEN-1:0] alu_in_y,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    exec_csr_unit_if.slave  csr,
    input  logic            irq_external,
    input  logic            irq_timer,
    input  logic            irq_software,
    input  logic [15:0]     irq_fast,
    input  logic [XLEN-1:0] pc_value,
    output logic            interrupt_taken,
    output logic [XLEN-1:0] mtvec_out
);

    logic [3:0] dec_op;
    logic [3:0] op;
    logic [4:0] shamt;
    logic       unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    // ALU-control decoder
    always_comb begin
        dec_op = ALU_ADD;
        case (aluop_in)
            ALUOP_BRANCH: begin
                case (func3)
                    3'b000:  dec_op = ALU_BEQ;
                    3'b001:  dec_op = ALU_BNE;
                    3'b100:  dec_op = ALU_BLT;
                    3'b101:  dec_op = ALU_BGE;
                    3'b110:  dec_op = ALU_BLTU;
                    3'b111:  dec_op = ALU_BGEU;
                    default: dec_op = ALU_ADD;
                endcase
            end
            ALUOP_ARITH: begin
                case (func3)
                    3'b000:  dec_op = (func7[5] && !is_immediate) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_op = ALU_SLL;
                    3'b010:  dec_op = ALU_SLT;
                    3'b011:  dec_op = ALU_SLTU;
                    3'b100:  dec_op = ALU_XOR;
                    3'b101:  dec_op = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end
            default: dec_op = ALU_ADD;
        endcase
    end

    assign aluop_out = dec_op;
    assign op        = op_override_en ? op_override : dec_op;
    assign shamt     = alu_in_y[4:0];

    // Branch ops return 0 when taken so that zero doubles as the taken flag
    always_comb begin
        alu_out = '0;
        case (op)
            ALU_AND:  alu_out = alu_in_x & alu_in_y;
            ALU_OR:   alu_out = alu_in_x | alu_in_y;
            ALU_ADD:  alu_out = alu_in_x + alu_in_y;
            ALU_XOR:  alu_out = alu_in_x ^ alu_in_y;
            ALU_SLL:  alu_out = alu_in_x << shamt;
            ALU_SRL:  alu_out = alu_in_x >> shamt;
            ALU_SUB:  alu_out = alu_in_x - alu_in_y;
            ALU_SRA:  alu_out = XLEN'($signed(alu_in_x) >>> shamt);
            ALU_SLT:  alu_out = XLEN'($signed(alu_in_x) < $signed(alu_in_y));
            ALU_SLTU: alu_out = XLEN'(alu_in_x < alu_in_y);
            ALU_BEQ:  alu_out = XLEN'(!(alu_in_x == alu_in_y));
            ALU_BNE:  alu_out = XLEN'(!(alu_in_x != alu_in_y));
            ALU_BLT:  alu_out = XLEN'(!($signed(alu_in_x) < $signed(alu_in_y)));
            ALU_BGE:  alu_out = XLEN'(!($signed(alu_in_x) >= $signed(alu_in_y)));
            ALU_BLTU: alu_out = XLEN'(!(alu_in_x < alu_in_y));
            default:  alu_out = XLEN'(!(alu_in_x >= alu_in_y));
        endcase
    end

    assign zero = (alu_out == '0);

    exec_csr_regfile #(
        .MHARTID  (MHARTID),
        .MISA_VAL (MISA_VAL)
    ) u_regfile (
        .clk             (clk),
        .reset           (reset),
        .func3           (func3),
        .csr             (csr),
        .irq_external    (irq_external),
        .irq_timer       (irq_timer),
        .irq_software    (irq_software),
        .irq_fast        (irq_fast),
        .pc_value        (pc_value),
        .interrupt_taken (interrupt_taken),
        .mtvec_out       (mtvec_out)
    );

endmodule

// File: tb/tb_exec_csr_unit.sv
// Directed bench for exec_csr_unit: ALU vector table plus CSR/interrupt sequences.
module tb_exec_csr_unit;

    logic        clk;
    logic        reset;
    logic        is_immediate;
    logic [1:0]  aluop_in;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic        op_override_en;
    logic [3:0]  op_override;
    logic [3:0]  aluop_out;
    logic [31:0] alu_in_x, alu_in_y, alu_out;
    logic        zero;
    logic        irq_external, irq_timer, irq_software;
    logic [15:0] irq_fast;
    logic [31:0] pc_value;
    logic        interrupt_taken;
    logic [31:0] mtvec_out;

    int checks   = 0;
    int failures = 0;

    exec_csr_unit_if csr_bus ();

    exec_csr_unit dut (
        .clk             (clk),
        .reset           (reset),
        .is_immediate    (is_immediate),
        .aluop_in        (aluop_in),
        .func7           (func7),
        .func3           (func3),
        .op_override_en  (op_override_en),
        .op_override     (op_override),
        .aluop_out       (aluop_out),
        .alu_in_x        (alu_in_x),
        .alu_in_y        (alu_in_y),
        .alu_out         (alu_out),
        .zero            (zero),
        .csr             (csr_bus),
        .irq_external    (irq_external),
        .irq_timer       (irq_timer),
        .irq_software    (irq_software),
        .irq_fast        (irq_fast),
        .pc_value        (pc_value),
        .interrupt_taken (interrupt_taken),
        .mtvec_out       (mtvec_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic        ovr_en;
        logic [3:0]  ovr;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  exp_op;
        logic [31:0] exp_out;
        logic        exp_zero;
    } alu_vec_t;

    localparam int unsigned NVEC = 21;
    alu_vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        csr_bus.csr_address = a;
        #1;
        check(name, csr_bus.csr_data_out, exp);
    endtask

    // One-cycle CSR write; old value must be visible while the write is pending
    task automatic csr_wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                          input logic [4:0] im, input logic [31:0] exp_old, input string name);
        @(negedge clk);
        func3                    = f3;
        csr_bus.csr_address      = a;
        csr_bus.csr_data_in      = d;
        csr_bus.csr_immediate    = im;
        csr_bus.csr_write_enable = 1'b1;
        #1;
        check(name, csr_bus.csr_data_out, exp_old);
        @(negedge clk);
        csr_bus.csr_write_enable = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b10, 3'b000, 7'h20, 1'b0, 1'b0, 4'd0, 32'd5,          32'd7,          4'd6,  32'hFFFFFFFE, 1'b0};
        vecs[1]  = '{2'b10, 3'b000, 7'h20, 1'b1, 1'b0, 4'd0, 32'd5,          32'd7,          4'd2,  32'd12,       1'b0};
        vecs[2]  = '{2'b01, 3'b100, 7'h00, 1'b0, 1'b0, 4'd0, 32'hFFFFFFFF,   32'd1,          4'd12, 32'd0,        1'b1};
        vecs[3]  = '{2'b01, 3'b110, 7'h00, 1'b0, 1'b0, 4'd0, 32'hFFFFFFFF,   32'd1,          4'd14, 32'd1,        1'b0};
        vecs[4]  = '{2'b10, 3'b101, 7'h20, 1'b0, 1'b0, 4'd0, 32'h80000000,   32'h21,         4'd7,  32'hC0000000, 1'b0};
        vecs[5]  = '{2'b10, 3'b101, 7'h00, 1'b0, 1'b0, 4'd0, 32'h80000000,   32'h21,         4'd5,  32'h40000000, 1'b0};
        vecs[6]  = '{2'b00, 3'b111, 7'h20, 1'b0, 1'b0, 4'd0, 32'd3,          32'd4,          4'd2,  32'd7,        1'b0};
        vecs[7]  = '{2'b00, 3'b000, 7'h00, 1'b0, 1'b1, 4'd3, 32'h0000F0F0,   32'h00000FF0,   4'd2,  32'h0000FF00, 1'b0};
        vecs[8]  = '{2'b10, 3'b000, 7'h20, 1'b0, 1'b0, 4'd0, 32'd9,          32'd9,          4'd6,  32'd0,        1'b1};
        vecs[9]  = '{2'b01, 3'b000, 7'h00, 1'b0, 1'b0, 4'd0, 32'd5,          32'd5,          4'd10, 32'd0,        1'b1};
        vecs[10] = '{2'b01, 3'b001, 7'h00, 1'b0, 1'b0, 4'd0, 32'd5,          32'd5,          4'd11, 32'd1,        1'b0};
        vecs[11] = '{2'b01, 3'b010, 7'h00, 1'b0, 1'b0, 4'd0, 32'd1,          32'd2,          4'd2,  32'd3,        1'b0};
        vecs[12] = '{2'b10, 3'b010, 7'h00, 1'b0, 1'b0, 4'd0, 32'hFFFFFFFE,   32'd1,          4'd8,  32'd1,        1'b0};
        vecs[13] = '{2'b10, 3'b011, 7'h00, 1'b0, 1'b0, 4'd0, 32'hFFFFFFFE,   32'd1,          4'd9,  32'd0,        1'b1};
        vecs[14] = '{2'b10, 3'b001, 7'h00, 1'b0, 1'b0, 4'd0, 32'd1,          32'h25,         4'd4,  32'h20,       1'b0};
        vecs[15] = '{2'b10, 3'b110, 7'h00, 1'b0, 1'b0, 4'd0, 32'hF0,         32'h0F,         4'd1,  32'hFF,       1'b0};
        vecs[16] = '{2'b10, 3'b111, 7'h00, 1'b0, 1'b0, 4'd0, 32'hF0,         32'h0F,         4'd0,  32'd0,        1'b1};
        vecs[17] = '{2'b11, 3'b100, 7'h20, 1'b0, 1'b0, 4'd0, 32'd10,         32'd20,         4'd2,  32'd30,       1'b0};
        vecs[18] = '{2'b01, 3'b101, 7'h00, 1'b0, 1'b0, 4'd0, 32'hFFFFFFFF,   32'd1,          4'd13, 32'd1,        1'b0};
        vecs[19] = '{2'b01, 3'b111, 7'h00, 1'b0, 1'b0, 4'd0, 32'hFFFFFFFF,   32'd1,          4'd15, 32'd0,        1'b1};
        vecs[20] = '{2'b10, 3'b101, 7'h20, 1'b1, 1'b0, 4'd0, 32'hFFFFFF00,   32'd4,          4'd7,  32'hFFFFFFF0, 1'b0};

        reset                    = 1'b1;
        is_immediate             = 1'b0;
        aluop_in                 = 2'b00;
        func7                    = 7'h00;
        func3                    = 3'b000;
        op_override_en           = 1'b0;
        op_override              = 4'd0;
        alu_in_x                 = '0;
        alu_in_y                 = '0;
        irq_external             = 1'b0;
        irq_timer                = 1'b0;
        irq_software             = 1'b0;
        irq_fast                 = '0;
        pc_value                 = '0;
        csr_bus.csr_write_enable = 1'b0;
        csr_bus.csr_address      = '0;
        csr_bus.csr_immediate    = '0;
        csr_bus.csr_data_in      = '0;

        repeat (2) @(negedge clk);
        reset = 1'b0;

        rd(12'h300, 32'h0, "reset_mstatus");
        rd(12'h301, 32'h40000100, "reset_misa");
        rd(12'hF14, 32'h0, "mhartid");
        rd(12'hF11, 32'h0, "mvendorid");
        check("reset_mtvec_out", mtvec_out, 32'h0);
        check("reset_irq_taken", 32'(interrupt_taken), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            aluop_in       = vecs[i].aluop;
            func3          = vecs[i].f3;
            func7          = vecs[i].f7;
            is_immediate   = vecs[i].imm;
            op_override_en = vecs[i].ovr_en;
            op_override    = vecs[i].ovr;
            alu_in_x       = vecs[i].x;
            alu_in_y       = vecs[i].y;
            #1;
            check($sformatf("vec%0d_op", i),   32'(aluop_out), 32'(vecs[i].exp_op));
            check($sformatf("vec%0d_out", i),  alu_out,        vecs[i].exp_out);
            check($sformatf("vec%0d_zero", i), 32'(zero),      32'(vecs[i].exp_zero));
        end
        op_override_en = 1'b0;

        csr_wr(3'b001, 12'h340, 32'hDEADBEEF, 5'h0, 32'h0, "csrrw_old");
        rd(12'h340, 32'hDEADBEEF, "mscratch_rw");
        csr_wr(3'b111, 12'h340, 32'h0, 5'h0F, 32'hDEADBEEF, "csrrci_old");
        rd(12'h340, 32'hDEADBEE0, "mscratch_rci");
        csr_wr(3'b010, 12'h305, 32'h100, 5'h0, 32'h0, "mtvec_old");
        check("mtvec_out", mtvec_out, 32'h100);
        csr_wr(3'b001, 12'h301, 32'h0, 5'h0, 32'h40000100, "misa_old");
        rd(12'h301, 32'h40000100, "misa_ro");
        csr_wr(3'b001, 12'hB00, 32'h1234, 5'h0, 32'h0, "mcycle_old");
        rd(12'hB00, 32'h0, "mcycle_absent");
        csr_wr(3'b001, 12'h341, 32'h123, 5'h0, 32'h0, "mepc_old");
        rd(12'h341, 32'h120, "mepc_align");
        csr_wr(3'b001, 12'h300, 32'hFFFFFFFF, 5'h0, 32'h0, "mstatus_old");
        rd(12'h300, 32'h88, "mstatus_mask");
        csr_wr(3'b001, 12'h300, 32'h8, 5'h0, 32'h88, "mstatus_old2");
        csr_wr(3'b001, 12'h304, 32'h80, 5'h0, 32'h0, "mie_old");

        // Timer request arrives during a CSR write: entry must wait one cycle
        @(negedge clk);
        func3                    = 3'b001;
        csr_bus.csr_address      = 12'h340;
        csr_bus.csr_data_in      = 32'h1;
        csr_bus.csr_write_enable = 1'b1;
        irq_timer                = 1'b1;
        pc_value                 = 32'h100;
        @(negedge clk);
        csr_bus.csr_write_enable = 1'b0;
        check("irq_deferred", 32'(interrupt_taken), 32'h0);
        rd(12'h340, 32'h1, "write_beats_irq");
        @(negedge clk);
        check("irq_taken", 32'(interrupt_taken), 32'h1);
        rd(12'h341, 32'h100, "irq_mepc");
        rd(12'h342, 32'h80000007, "irq_mcause");
        rd(12'h300, 32'h80, "irq_mstatus");
        rd(12'h344, 32'h80, "mip_timer");
        @(negedge clk);
        check("irq_pulse_end", 32'(interrupt_taken), 32'h0);

        irq_external = 1'b1;
        irq_software = 1'b1;
        pc_value     = 32'h204;
        csr_wr(3'b001, 12'h304, 32'hFFFFFFFF, 5'h0, 32'h80, "mie_old2");
        csr_wr(3'b001, 12'h300, 32'h8, 5'h0, 32'h80, "mstatus_reen");
        @(negedge clk);
        check("irq2_taken", 32'(interrupt_taken), 32'h1);
        rd(12'h342, 32'h8000000B, "irq_prio_ext");
        rd(12'h341, 32'h204, "irq2_mepc");

        irq_fast = 16'h0004;
        csr_wr(3'b001, 12'h300, 32'h8, 5'h0, 32'h80, "mstatus_reen2");
        @(negedge clk);
        rd(12'h342, 32'h80000012, "irq_prio_fast");
        rd(12'h344, 32'h00040888, "mip_all");

        irq_external = 1'b0;
        irq_software = 1'b0;
        irq_timer    = 1'b0;
        irq_fast     = '0;

        // Reset during a write: the write is discarded
        @(negedge clk);
        func3                    = 3'b001;
        csr_bus.csr_address      = 12'h340;
        csr_bus.csr_data_in      = 32'h55;
        csr_bus.csr_write_enable = 1'b1;
        reset                    = 1'b1;
        @(negedge clk);
        csr_bus.csr_write_enable = 1'b0;
        reset                    = 1'b0;
        rd(12'h340, 32'h0, "rst_mscratch");
        rd(12'h305, 32'h0, "rst_mtvec");
        rd(12'h304, 32'h0, "rst_mie");
        rd(12'h300, 32'h0, "rst_mstatus");
        rd(12'h341, 32'h0, "rst_mepc");
        rd(12'h342, 32'h0, "rst_mcause");
        check("rst_mtvec_out", mtvec_out, 32'h0);
        check("rst_irq_taken", 32'(interrupt_taken), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_csr_unit.md
Name: exec_csr_unit

Overview:
Combinational execute datapath plus machine-mode CSR file for the multicycle RV32I core.
- ALU-control decoder turns aluop/func3/func7 into a 4-bit ALU operation; the core can override it.
- The 32-bit ALU produces the result and a zero flag; the control unit uses the zero flag for branch decisions.
- The CSR section implements Zicsr read/modify/write, interrupt-pending logic and minimal interrupt entry.

Parameters:
- MHARTID, 32'h0, value read at CSR 0xF14.
- MISA_VAL, 32'h40000100, value read at misa 0x301 (RV32I); writes are ignored.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high.
- is_immediate in 1: I-type arithmetic instruction.
- aluop_in in 2: class from the control unit.
- func7 in 7, func3 in 3: instruction fields.
- op_override_en in 1, op_override in 4: when op_override_en=1, op_override replaces the decoded op.
- aluop_out out 4: decoded op, before the override.
- alu_in_x in 32, alu_in_y in 32: operands.
- alu_out out 32: result.
- zero out 1: high when alu_out==0.
- csr_write_enable in 1, csr_address in 12, csr_immediate in 5, csr_data_in in 32: CSR access.
- csr_data_out out 32: current value of the addressed CSR.
- irq_external, irq_timer, irq_software in 1 each; irq_fast in 16: interrupt requests.
- pc_value in 32: PC of the current instruction.
- interrupt_taken out 1: one-cycle pulse.
- mtvec_out out 32: trap vector.

Behaviour:
- Op encoding, all combinational:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SRA.
  - 8 SLT, 9 SLTU: result 1/0.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU: result 0 when the branch is taken, 1 otherwise, so zero=taken.
- Shifts use alu_in_y[4:0].
- Decoder by aluop_in:
  - 00 → ADD.
  - 01 → branch op by func3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 → ADD).
  - 10 → func3: 000 ADD, or SUB when func7[5]=1 and is_immediate=0; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if func7[5] else SRL (for both R- and I-type); 110 OR; 111 AND.
  - 11 → ADD.
- CSR map:
  - RW: mstatus 0x300 (only bits MIE[3] and MPIE[7] are writable), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits [1:0] read 0), mcause 0x342, mtval 0x343.
  - RO: misa 0x301, mip 0x344, mhartid 0xF14, mvendorid 0xF11=0, marchid 0xF12=0, mimpid 0xF13=0.
  - Unmapped addresses read 0; writes to them are ignored.
- mip is combinational from the request inputs: [3]=irq_software, [7]=irq_timer, [11]=irq_external, [31:16]=irq_fast; all other bits are 0.
- csr_data_out is combinational and shows the old value during the write cycle.
- Operand src = func3[2] ? zero-extended csr_immediate : csr_data_in.
- Ops, applied at clk when csr_write_enable=1:
  - func3[1:0]=01 → write src.
  - 10 → old | src.
  - 11 → old & ~src.
  - 00 → no write.
- Writes to RO CSRs are ignored.
- Pending = mstatus.MIE & |(mie & mip).
- Interrupt entry occurs on a clk edge where pending=1 and csr_write_enable=0:
  - mepc←pc_value.
  - mcause←{1'b1, code}; code is the lowest-priority-resolved index, highest first: fast 31..16, then 11, 3, 7.
  - MPIE←MIE, MIE←0.
  - interrupt_taken=1 for exactly that one cycle.
- A CSR write in the same cycle as pending has priority; interrupt entry is deferred.
- Reset:
  - All RW CSRs clear to 0, except mtvec which clears to 32'h0.
  - Counters clear to 0; interrupt_taken=0.
  - Reset applied mid-operation discards any pending write.
- mtvec_out = mtvec.

Optional Feature:
CSR_COUNTERS_EN
- Defined: 64-bit mcycle increments every non-reset cycle.
  - Readable/writable at 0xB00 (low) and 0xB80 (high).
  - Read-only aliases at cycle 0xC00 and 0xC80.
  - On the cycle of a CSR write to mcycle, the write wins over the increment.
- Undefined: all four addresses read 0 and ignore writes.

Decomposition:
- Package: ALU op localparams, aluop class codes, CSR address constants, mip bit positions.
- One natural sub-module: exec_csr_regfile (CSR storage and interrupt entry); the ALU and decoder stay inline.

Test Plan:
- aluop_in=10, func3=000, func7=0100000, is_immediate=0, x=5, y=7 → aluop_out=6, alu_out=32'hFFFFFFFE, zero=0. Same inputs with is_immediate=1 → ADD, alu_out=12.
- aluop_in=01, func3=100 (BLT), x=32'hFFFFFFFF, y=1 → zero=1. Same operands with func3=110 (BLTU) → zero=0.
- SRA x=32'h80000000, y=32'h21 → alu_out=32'hC0000000. SRL same operands → alu_out=32'h40000000.
- CSRRW mscratch←32'hDEADBEEF: read back 32'hDEADBEEF. Then CSRRCI imm=5'h0F → 32'hDEADBEE0. During the write cycle csr_data_out still shows the old value.
- mstatus=8, mie=32'h80, irq_timer=1, pc_value=32'h100 → next edge: interrupt_taken=1, mepc=32'h100, mcause=32'h80000007, mstatus=32'h80.
- Reset asserted after writes → mtvec, mscratch, mie and mstatus all read 0. Write to misa → misa still reads MISA_VAL.
